// File: rtl/mss_uart_rx_monitor.sv
// mss_uart_rx_monitor: fabric-side 8N1 UART receiver for the MSS MMUART_1 TX line.
// Decoded bytes are presented on a valid/ready holding register, with framing-error and
// overrun pulses.
// Optional parity support (PARITY state, PARITY_ODD parameter, o_parity_err port) is
// compiled in when the macro UART_RX_PARITY_EN is defined.
module mss_uart_rx_monitor #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD   = 0
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic       PAR_ODD  = 1'(PARITY_ODD);
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  logic [2:0]        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic              par_bad, par_bad_next;

  logic              deliver_c;
  logic              frame_err_c;
  logic              parity_err_c;
  logic              overrun_c;
  logic              valid_next;
  logic [DATA_W-1:0] data_next;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Metastability chain on the asynchronous line; preloads to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
    end
  end

  // State register and frame datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      idx     <= idx_next;
      shreg   <= shreg_next;
      par_bad <= par_bad_next;
    end
  end

  // Next-state logic: mid-bit sampling driven by the down-counter.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    idx_next     = idx;
    shreg_next   = shreg;
    par_bad_next = par_bad;
    deliver_c    = 1'b0;
    frame_err_c  = 1'b0;
    parity_err_c = 1'b0;

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          cnt_next   = HALF_LOAD;
        end
      end

      S_START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_next = S_IDLE;
          end else begin
            state_next   = S_DATA;
            cnt_next     = BIT_LOAD;
            idx_next     = '0;
            par_bad_next = 1'b0;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt == '0) begin
          shreg_next = {rx_s, shreg[DATA_W-1:1]};
          cnt_next   = BIT_LOAD;
          if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == '0) begin
          if (((^shreg) ^ rx_s ^ PAR_ODD) != 1'b0) begin
            parity_err_c = 1'b1;
            par_bad_next = 1'b1;
          end
          state_next = S_STOP;
          cnt_next   = BIT_LOAD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            deliver_c  = !par_bad;
            state_next = S_IDLE;
          end else begin
            frame_err_c = 1'b1;
            state_next  = S_BREAK;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end

      S_BREAK: begin
        if (rx_s) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Holding-register handoff: replace on simultaneous accept, drop and flag when full.
  always_comb begin
    valid_next = o_valid;
    data_next  = o_data;
    overrun_c  = 1'b0;

    if (o_valid && i_ready) begin
      valid_next = 1'b0;
    end

    if (deliver_c) begin
      if (!o_valid || i_ready) begin
        data_next  = shreg;
        valid_next = 1'b1;
      end else begin
        overrun_c = 1'b1;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_data       <= data_next;
      o_valid      <= valid_next;
      o_frame_err  <= frame_err_c;
      o_overrun    <= overrun_c;
      o_busy       <= (state_next != S_IDLE);
`ifdef UART_RX_PARITY_EN
      o_parity_err <= parity_err_c;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  // Parity path is inert without the option; keep the signal consumed.
  logic unused_parity;
  assign unused_parity = parity_err_c;
`endif

endmodule

// File: tb/tb_mss_uart_rx_monitor.sv
// Testbench for mss_uart_rx_monitor: directed frames plus randomized frames
// against a byte-level scoreboard.
module tb_mss_uart_rx_monitor;

  localparam int unsigned CLKS = 8;
  localparam int unsigned SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PODD = 0;
  localparam int unsigned NBITS = 10;
`else
  localparam int unsigned NBITS = 9;
`endif
  // Start edge to o_valid rise: synchronizer + idle detect + half bit + remaining bits.
  localparam int unsigned LAT = SYNC + 1 + CLKS / 2 + NBITS * CLKS;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  mss_uart_rx_monitor #(
    .CLKS_PER_BIT(CLKS),
    .SYNC_STAGES (SYNC)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ODD  (PODD)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(o_parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int n_rise = 0, n_fe = 0, n_ov = 0, n_pe = 0;
  int busy_run = 0, max_busy = 0;
  logic prev_valid = 1'b0;
  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  // Observer on the falling edge: counts pulses and records accepted bytes.
  always @(negedge clk) begin
    if (o_valid && !prev_valid) begin
      n_rise++;
      rise_cyc = cyc;
    end
    prev_valid = o_valid;
    if (o_frame_err) n_fe++;
    if (o_overrun) n_ov++;
`ifdef UART_RX_PARITY_EN
    if (o_parity_err) n_pe++;
`endif
    if (o_busy) begin
      busy_run++;
      if (busy_run > max_busy) max_busy = busy_run;
    end else begin
      busy_run = 0;
    end
    if (o_valid && i_ready && !reset) acc_q.push_back(o_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    i_rx = 1'b1;
    repeat (n * CLKS) @(posedge clk);
    #1;
  endtask

  // Sends one frame starting just after a clock edge; ends just after the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ 1'(PODD) ^ par_flip);
`else
    if (par_flip) i_rx = 1'b1;
`endif
    drive_bit(stop);
  endtask

  task automatic compare_queues(input string tag);
    chk({tag, "_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && acc_q.size() > 0) begin
      chk({tag, "_byte"}, 32'(acc_q.pop_front()), 32'(exp_q.pop_front()));
    end
    acc_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       rdy;
    logic       model_valid;
    logic [7:0] model_data;
    int         exp_ov;

    reset = 1'b1;
    i_rx = 1'b1;
    i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(o_data), 32'h00);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ferr", 32'(o_frame_err), 32'd0);
    chk("rst_ovr", 32'(o_overrun), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    reset = 1'b0;
    idle_bits(2);

    // Single byte, latency and consume.
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("t1_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
    chk("t1_data", 32'(o_data), 32'hA5);
    chk("t1_valid", 32'(o_valid), 32'd1);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    chk("t1_valid_clr", 32'(o_valid), 32'd0);
    exp_q.push_back(8'hA5);
    compare_queues("t1_acc");

    // Back-to-back with consumer stalled: second byte overruns.
    n_ov = 0;
    n_fe = 0;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    chk("t2_data", 32'(o_data), 32'h3C);
    chk("t2_valid", 32'(o_valid), 32'd1);
    chk("t2_overrun", 32'(n_ov), 32'd1);
    chk("t2_ferr", 32'(n_fe), 32'd0);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    exp_q.push_back(8'h3C);
    compare_queues("t2_acc");

    // Short glitch on an idle line.
    idle_bits(2);
    n_rise = 0; n_fe = 0; n_ov = 0; max_busy = 0;
    i_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle_bits(3);
    chk("t3_no_valid", 32'(n_rise), 32'd0);
    chk("t3_no_err", 32'(n_fe + n_ov), 32'd0);
    chk("t3_busy_bound", 32'(max_busy >= 1 && max_busy <= 4), 32'd1);

    // Framing error followed by a held-low break, then a good frame.
    n_rise = 0; n_fe = 0; n_ov = 0;
    send_frame(8'h55, 1'b0, 1'b0);
    i_rx = 1'b0;
    repeat (20 * CLKS) @(posedge clk);
    #1;
    idle_bits(2);
    chk("t4_ferr", 32'(n_fe), 32'd1);
    chk("t4_no_valid", 32'(n_rise), 32'd0);
    chk("t4_no_ovr", 32'(n_ov), 32'd0);
    send_frame(8'h12, 1'b1, 1'b0);
    chk("t4_next_data", 32'(o_data), 32'h12);
    chk("t4_next_valid", 32'(o_valid), 32'd1);
    chk("t4_ferr_once", 32'(n_fe), 32'd1);

    // Reset during data bit 4 while a byte is still held.
    idle_bits(1);
    b = 8'h0F;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    i_rx = b[4];
    repeat (CLKS / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t5_data", 32'(o_data), 32'h00);
    chk("t5_valid", 32'(o_valid), 32'd0);
    chk("t5_busy", 32'(o_busy), 32'd0);
    chk("t5_errs", 32'({o_frame_err, o_overrun}), 32'd0);
    n_rise = 0; n_fe = 0;
    idle_bits(12);
    chk("t5_quiet", 32'(n_rise + n_fe), 32'd0);
    i_ready = 1'b1;
    send_frame(8'hF0, 1'b1, 1'b0);
    i_ready = 1'b0;
    exp_q.push_back(8'hF0);
    compare_queues("t5_acc");

    // Randomized frames and consumer behaviour against the byte-level model.
    idle_bits(1);
    model_valid = 1'b0;
    model_data = 8'h00;
    exp_ov = 0;
    n_ov = 0;
    for (int f = 0; f < 12; f++) begin
      b = 8'($urandom);
      rdy = 1'($urandom_range(0, 1));
      i_ready = rdy;
      if (rdy && model_valid) begin
        exp_q.push_back(model_data);
        model_valid = 1'b0;
      end
      send_frame(b, 1'b1, 1'b0);
      if (rdy) exp_q.push_back(b);
      else if (model_valid) exp_ov++;
      else begin
        model_valid = 1'b1;
        model_data = b;
      end
      chk("rnd_valid", 32'(o_valid), 32'(model_valid));
      if (model_valid) chk("rnd_data", 32'(o_data), 32'(model_data));
      chk("rnd_overrun", 32'(n_ov), 32'(exp_ov));
      idle_bits(int'($urandom_range(0, 2)));
    end
    if (model_valid) exp_q.push_back(model_data);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    compare_queues("rnd_acc");

`ifdef UART_RX_PARITY_EN
    // Parity: good parity delivers, bad parity discards with a pulse.
    idle_bits(1);
    n_pe = 0; n_rise = 0;
    i_ready = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    chk("par_ok_pulse", 32'(n_pe), 32'd0);
    exp_q.push_back(8'h07);
    compare_queues("par_ok_acc");
    n_rise = 0;
    send_frame(8'h07, 1'b1, 1'b1);
    chk("par_bad_pulse", 32'(n_pe), 32'd1);
    chk("par_bad_no_valid", 32'(n_rise), 32'd0);
    i_ready = 1'b0;
`endif

    idle_bits(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
